mem_port_arbiter: RTL

- Shares the single synchronous port of the data/instruction block RAM between two requesters.
- Port 0 is the CPU fetch/load-store path driven by the CPU FSM. Port 1 is the peripheral path (VGA/IO reader or DMA).
- Port 0 has fixed priority; a starvation counter guarantees port 1 forward progress.
- Read data returns after a fixed pipeline latency, tagged to the issuing port.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one synchronous block-RAM port between the CPU path (port 0, fixed
// priority) and the peripheral path (port 1). A saturating wait counter forces
// a port-1 grant after MAX_WAIT consecutive denials. Reads are tracked by a
// {valid, port} tag pipeline RD_LAT deep so each response is steered to the
// port that issued it.

module mem_port_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 16,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   // Read tag: which port a read belongs to, and whether the slot holds a read.
   typedef struct packed {
      logic valid;
      logic port;
   } tag_t;

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   logic [3:0] wait_cnt_q;
   logic [3:0] wait_cnt_d;
   tag_t       tag_q [RD_LAT];
   tag_t       tag_d [RD_LAT];
   tag_t       tag_out_s;

   // Arbitration: port 0 wins unless port 1 has been starved for MAX_WAIT cycles.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (Reset) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end else if (req1 && (!req0 || (wait_cnt_q == MAX_WAIT_C))) begin
         gnt1 = 1'b1;
      end else if (req0) begin
         gnt0 = 1'b1;
      end else begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   // RAM port mux: granted port drives the RAM; idle cycles park on port 0 fields.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (Reset) begin
         ram_en    = 1'b0;
         ram_we    = 1'b0;
         ram_addr  = '0;
         ram_wdata = '0;
      end else if (gnt1) begin
         ram_en    = 1'b1;
         ram_we    = we1;
         ram_addr  = addr1;
         ram_wdata = wdata1;
      end else begin
         ram_en    = gnt0;
         ram_we    = gnt0 & we0;
         ram_addr  = addr0;
         ram_wdata = wdata0;
      end
   end

   // Starvation counter: count denied port-1 cycles, saturating, cleared on grant or drop.
   always_comb begin
      wait_cnt_d = 4'd0;
      if (req1 && !gnt1) begin
         if (wait_cnt_q >= MAX_WAIT_C) begin
            wait_cnt_d = MAX_WAIT_C;
         end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
         end
      end else begin
         wait_cnt_d = 4'd0;
      end
   end

   // Tag pipeline next state: new read tag enters at stage 0, older tags shift on.
   always_comb begin
      for (int i = 0; i < RD_LAT; i++) begin
         tag_d[i] = tag_t'(2'b00);
      end
      tag_d[0].valid = ram_en & ~ram_we;
      tag_d[0].port  = gnt1;
      for (int i = 1; i < RD_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   // State registers: counter and tag pipeline, cleared by synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         wait_cnt_q <= 4'd0;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_q[i] <= tag_t'(2'b00);
         end
      end else begin
         wait_cnt_q <= wait_cnt_d;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   assign tag_out_s = tag_q[RD_LAT-1];

   // Response steering: exiting tag selects rvalid; rdata passes through while valid.
   always_comb begin
      rvalid0 = 1'b0;
      rvalid1 = 1'b0;
      rdata   = '0;
      if (Reset) begin
         rvalid0 = 1'b0;
         rvalid1 = 1'b0;
         rdata   = '0;
      end else if (tag_out_s.valid) begin
         rvalid0 = ~tag_out_s.port;
         rvalid1 = tag_out_s.port;
         rdata   = ram_rdata;
      end else begin
         rvalid0 = 1'b0;
         rvalid1 = 1'b0;
         rdata   = '0;
      end
   end

endmodule
